// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg
// Shared types and constants for the counter sequencer: FSM state
// encoding, direction levels and the event-priority slot of each button
// (a lower index wins when several events land in the same cycle).
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_CLEAR = 3'd3,
    ST_LOAD  = 3'd4
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int EV_CLR  = 0;
  localparam int EV_LOAD = 1;
  localparam int EV_DIR  = 2;
  localparam int EV_RUN  = 3;
  localparam int NUM_EV  = 4;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Cleans one raw board button: 2-flop synchronizer, then a debounce
// counter, then a one-cycle rising-edge pulse of the debounced level.
// A stable press shows up on rise 2+DB_CYCLES+1 cycles later.
// Ports:
//   clk      system clock
//   clr_n    asynchronous active-low reset
//   btn_raw  raw button, active high, asynchronous to clk
//   rise     one-cycle pulse on the debounced level going 0->1
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_raw,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic [CW-1:0] count_q, count_d;

  // The count only advances while the synced input disagrees with the
  // debounced level; any agreeing cycle restarts the run.
  always_comb begin
    db_d    = db_q;
    count_d = '0;
    if (sync2_q != db_q) begin
      if (count_q == CNT_LAST) begin
        db_d    = ~db_q;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      count_q   <= count_d;
    end
  end

  assign rise = db_q & ~db_prev_q;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl
// Sequencer for the up/down counter datapath. Debounces the four board
// buttons, applies clr > load > dir > run priority and drives single-cycle
// clear/load/step commands plus the direction level.
// Optional feature macro: COUNTER_CTRL_AUTO_RELOAD_EN -- when defined, a
// tick in RUN with cnt_q at its terminal value reloads the last preset
// instead of stepping.
// Ports:
//   clk, clr_n                        clock, async active-low reset
//   btn_clr/btn_load/btn_dir/btn_run  raw buttons, active high
//   sw_data                           preset switches, sampled on load
//   cnt_q                             counter value (auto-reload only)
//   cnt_clr, cnt_load, cnt_step       one-cycle commands
//   load_data                         value for cnt_load, held otherwise
//   cnt_dir                           0=up, 1=down
//   running                           high while in RUN
//
// state    | meaning
// ST_IDLE  | stopped, prescaler cleared
// ST_RUN   | prescaler counting, cnt_step on each wrap
// ST_PAUSE | stopped, prescaler holds its value
// ST_CLEAR | one cycle, cnt_clr=1, then IDLE
// ST_LOAD  | one cycle, cnt_load=1, back to RUN or PAUSE
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             btn_clr,
  input  logic             btn_load,
  input  logic             btn_dir,
  input  logic             btn_run,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_clr,
  output logic             cnt_load,
  output logic [WIDTH-1:0] load_data,
  output logic             cnt_step,
  output logic             cnt_dir,
  output logic             running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [NUM_EV-1:0] ev;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .clr_n(clr_n), .btn_raw(btn_clr), .rise(ev[EV_CLR])
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk(clk), .clr_n(clr_n), .btn_raw(btn_load), .rise(ev[EV_LOAD])
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
    .clk(clk), .clr_n(clr_n), .btn_raw(btn_dir), .rise(ev[EV_DIR])
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk(clk), .clr_n(clr_n), .btn_raw(btn_run), .rise(ev[EV_RUN])
  );

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             ret_run_q, ret_run_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic             reload;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    ret_run_d   = ret_run_q;
    load_data_d = load_data_q;
    presc_d     = presc_q;

    case (state_q)
      ST_RUN:            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      ST_PAUSE, ST_LOAD: presc_d = presc_q;
      default:           presc_d = '0;
    endcase

    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_LOAD:  state_d = ret_run_q ? ST_RUN : ST_PAUSE;
      default:  state_d = state_q;
    endcase

    // Only the highest-priority event of the cycle is considered; if it
    // does not apply in the current state the lower ones are still dropped.
    if (ev[EV_CLR]) begin
      state_d = ST_CLEAR;
      dir_d   = DIR_UP;
    end else if (ev[EV_LOAD]) begin
      if (state_q != ST_CLEAR) begin
        state_d     = ST_LOAD;
        load_data_d = sw_data;
        // A re-load while already in LOAD keeps the original return target.
        if (state_q != ST_LOAD) ret_run_d = (state_q == ST_RUN);
      end
    end else if (ev[EV_DIR]) begin
      dir_d = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
    end else if (ev[EV_RUN]) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        ST_RUN:            state_d = ST_PAUSE;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      ret_run_q   <= 1'b0;
      load_data_q <= '0;
      presc_q     <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      ret_run_q   <= ret_run_d;
      load_data_q <= load_data_d;
      presc_q     <= presc_d;
    end
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
  logic [WIDTH-1:0] preset_q, preset_d;
  logic             at_terminal;

  always_comb begin
    preset_d = preset_q;
    if (state_q == ST_LOAD) preset_d = load_data_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) preset_q <= '0;
    else        preset_q <= preset_d;
  end

  assign at_terminal = (dir_q == DIR_UP) ? (cnt_q == '1) : (cnt_q == '0);
  assign reload      = tick & at_terminal;
  assign load_data   = reload ? preset_q : load_data_q;
`else
  logic unused_cnt_q;
  assign unused_cnt_q = ^cnt_q;
  assign reload       = 1'b0;
  assign load_data    = load_data_q;
`endif

  // CLEAR/LOAD are never RUN, so a tick cannot overlap those pulses.
  assign cnt_step = tick & ~reload;
  assign cnt_load = (state_q == ST_LOAD) | reload;
  assign cnt_clr  = (state_q == ST_CLEAR);
  assign cnt_dir  = dir_q;
  assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       btn_clr, btn_load, btn_dir, btn_run;
  logic [7:0] sw_data, cnt_q;
  logic       cnt_clr, cnt_load, cnt_step, cnt_dir, running;
  logic [7:0] load_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  counter_ctrl #(.WIDTH(8), .TICK_DIV(4), .DB_CYCLES(3)) dut (
    .clk(clk), .clr_n(clr_n),
    .btn_clr(btn_clr), .btn_load(btn_load), .btn_dir(btn_dir), .btn_run(btn_run),
    .sw_data(sw_data), .cnt_q(cnt_q),
    .cnt_clr(cnt_clr), .cnt_load(cnt_load), .load_data(load_data),
    .cnt_step(cnt_step), .cnt_dir(cnt_dir), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cmd(input string tag, output int cnt);
    cnt = 0;
    do begin
      cyc(1);
      cnt++;
    end while (!(cnt_step || cnt_load) && cnt < 40);
    if (!(cnt_step || cnt_load)) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    clr_n = 1'b0; btn_clr = 1'b0; btn_load = 1'b0; btn_dir = 1'b0; btn_run = 1'b0;
    sw_data = 8'h00; cnt_q = 8'h55;
    cyc(3);
    check("reset_out", {cnt_clr, cnt_load, cnt_step, cnt_dir, running, load_data}, 32'd0);
    clr_n = 1'b1;
    cyc(3);
    check("idle_after_reset", running, 0);

    // run press: event after 2+3+1 cycles, step on presc==3
    btn_run = 1'b1;
    cyc(5); check("run_lat5", running, 0);
    cyc(1); check("run_lat6", running, 1);
    check("dir_up", cnt_dir, 0);
    cyc(2); check("step_early", cnt_step, 0);
    cyc(1); check("step_first", cnt_step, 1);
    cyc(1); btn_run = 1'b0;
    check("step_one_cycle", cnt_step, 0);
    cyc(3); check("step_period", cnt_step, 1);

    // one-cycle glitch
    cyc(6);
    btn_run = 1'b1; cyc(1); btn_run = 1'b0;
    cyc(8); check("glitch_ignored", running, 1);

    // load in RUN
    sw_data = 8'hA5; btn_load = 1'b1;
    cyc(5); check("load_lat5", cnt_load, 0);
    cyc(1);
    check("load_pulse", cnt_load, 1);
    check("load_data", load_data, 8'hA5);
    check("load_no_step", cnt_step, 0);
    cyc(1); btn_load = 1'b0; sw_data = 8'h3C;
    check("load_one_cycle", cnt_load, 0);
    check("load_ret_run", running, 1);
    check("load_data_held", load_data, 8'hA5);
    cyc(8);

    // dir twice
    btn_dir = 1'b1;
    cyc(5); check("dir_lat5", cnt_dir, 0);
    cyc(1); check("dir_toggle1", cnt_dir, 1);
    btn_dir = 1'b0; cyc(8);
    btn_dir = 1'b1;
    cyc(6); check("dir_toggle2", cnt_dir, 0);
    btn_dir = 1'b0; cyc(8);
    wait_cmd("align", n);
    wait_cmd("cadence", n);
    check("cadence", n, 4);

    // pause on the tick just seen: presc holds 1, resume steps 2 cycles in
    btn_run = 1'b1;
    cyc(4); check("step_before_pause", cnt_step, 1);
    cyc(2); check("paused", running, 0);
    btn_run = 1'b0;
    cyc(10); check("pause_no_step", {running, cnt_step}, 0);
    btn_run = 1'b1;
    cyc(6); check("resume", running, 1);
    cyc(1); check("resume_step_early", cnt_step, 0);
    cyc(1); check("resume_held_presc", cnt_step, 1);
    btn_run = 1'b0; cyc(6);

    // dir=1, pause, then clr+load together
    btn_dir = 1'b1;
    cyc(6); check("dir_set", cnt_dir, 1);
    btn_dir = 1'b0; cyc(6);
    btn_run = 1'b1;
    cyc(6); check("pause2", running, 0);
    btn_run = 1'b0; cyc(8);
    check("dir_before_clr", cnt_dir, 1);
    sw_data = 8'h5A; btn_clr = 1'b1; btn_load = 1'b1;
    cyc(5); check("clr_lat5", cnt_clr, 0);
    cyc(1);
    check("clr_pulse", cnt_clr, 1);
    check("clr_no_load", cnt_load, 0);
    check("clr_dir", cnt_dir, 0);
    cyc(1); btn_clr = 1'b0; btn_load = 1'b0;
    check("clr_one_cycle", {cnt_clr, cnt_load}, 0);
    check("load_dropped", load_data, 8'hA5);
    cyc(8);

    // IDLE cleared the prescaler: first step three cycles into RUN
    btn_run = 1'b1;
    cyc(6); check("idle_to_run", running, 1);
    cyc(2); check("idle_step_early", cnt_step, 0);
    cyc(1); check("idle_presc_cleared", cnt_step, 1);
    btn_run = 1'b0; cyc(6);

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    sw_data = 8'h10; btn_load = 1'b1;
    cyc(6); check("ar_load_pulse", cnt_load, 1);
    btn_load = 1'b0; cyc(1);
    cnt_q = 8'hFF;
    wait_cmd("ar_tick", n);
    check("ar_load", cnt_load, 1);
    check("ar_no_step", cnt_step, 0);
    check("ar_data", load_data, 8'h10);
    check("ar_running", running, 1);
`else
    cnt_q = 8'hFF;
    wait_cmd("wrap_tick", n);
    check("wrap_step", cnt_step, 1);
    check("wrap_no_load", cnt_load, 0);
`endif

    // reset mid-pulse
    wait_cmd("pre_reset", n);
    clr_n = 1'b0;
    #1;
    check("async_reset", {cnt_clr, cnt_load, cnt_step, cnt_dir, running, load_data}, 32'd0);
    cyc(2);
    clr_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencer for the 8-bit up/down counter datapath. Takes raw board buttons and data switches, then synchronizes, debounces and prioritizes them. Emits single-cycle clear, load and step commands plus a direction level, so the counter runs on a clean clock-enable tick instead of raw button edges. Sits between the board I/O and the counter in the counter_scan top level.

Parameters:
WIDTH, 8, counter/data width
TICK_DIV, 50_000_000, clk cycles per step while running (1 Hz at 50 MHz)
DB_CYCLES, 1_000_000, stable cycles required to accept a button level (20 ms)

Ports:
clk  in  1  system clock, all logic on rising edge
clr_n  in  1  asynchronous active-low reset
btn_clr  in  1  raw clear button, active high, asynchronous
btn_load  in  1  raw load button, active high, asynchronous
btn_dir  in  1  raw direction-toggle button, active high, asynchronous
btn_run  in  1  raw run/pause button, active high, asynchronous
sw_data  in  WIDTH  preset switches, sampled on load event
cnt_q  in  WIDTH  current counter value (used only with the optional feature)
cnt_clr  out  1  one-cycle clear command
cnt_load  out  1  one-cycle load command
load_data  out  WIDTH  value to load, valid while cnt_load=1, held otherwise
cnt_step  out  1  one-cycle count enable
cnt_dir  out  1  0=up, 1=down (level)
running  out  1  1 while FSM in RUN

Behaviour:
- One clock domain; reset is asynchronous and active-low (clr_n). All flops reset asynchronously.
- Reset values: cnt_clr=0, cnt_load=0, load_data=0, cnt_step=0, cnt_dir=0, running=0, FSM=IDLE, prescaler=0, sync/debounce state=0.
- Each button passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synced input differs from it for DB_CYCLES consecutive cycles.
- Event = rising edge of the debounced level, one cycle wide. Latency from a stable raw press to the event is 2+DB_CYCLES+1 cycles.
- A button held through reset produces exactly one event after release of reset plus the debounce time.
- Same-cycle events use priority clr > load > dir > run. Only the highest-priority event acts; the others in that cycle are dropped, not queued.
- FSM states: IDLE, RUN, PAUSE, CLEAR, LOAD.
  - IDLE --run--> RUN
  - RUN --run--> PAUSE
  - PAUSE --run--> RUN
  - any --clr--> CLEAR: 1 cycle, cnt_clr=1, cnt_dir forced 0, then IDLE.
  - any except CLEAR --load--> LOAD: 1 cycle, cnt_load=1, load_data=sw_data sampled in the event cycle. Returns to RUN if it came from RUN, else PAUSE.
  - dir event in any state toggles cnt_dir next cycle; no state change.
- Prescaler counts 0..TICK_DIV-1 only in RUN; it holds its value in PAUSE and is cleared in IDLE/CLEAR.
- cnt_step=1 for one cycle when the prescaler is at TICK_DIV-1 in RUN; the prescaler then wraps to 0.
- cnt_step is never asserted in the same cycle as cnt_clr or cnt_load. A tick coinciding with LOAD is lost.
- Counter wrap-around (0xFF+1, 0x00-1) is left to the datapath; the controller does not inspect cnt_q unless the optional feature is enabled.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronously). Any in-flight command pulse is truncated.
- TICK_DIV=1 means cnt_step is asserted every cycle in RUN.

Optional Feature:
COUNTER_CTRL_AUTO_RELOAD_EN
- Defined: a preset register (reset 0) captures load_data on each LOAD. In RUN, if a tick occurs while cnt_q is at terminal (all ones with dir=0, zero with dir=1), the controller issues cnt_load with load_data=preset instead of cnt_step. The FSM stays in RUN.
- Undefined: ticks always produce cnt_step, the counter wraps naturally, and cnt_q is unused.

Decomposition:
- Package counter_ctrl_pkg: state enum (IDLE, RUN, PAUSE, CLEAR, LOAD), direction constants DIR_UP=0 and DIR_DOWN=1, event-priority index constants.
- Sub-module btn_debounce (synchronizer + debounce counter + edge output), instantiated 4 times.
- The top module holds the FSM, prescaler and command outputs.

Test Plan:
(All scenarios use bench parameters TICK_DIV=4, DB_CYCLES=3.)
- Reset, press run held 10 cycles -> running=1 after 6 cycles; cnt_step pulses every 4 cycles; cnt_dir=0.
- Press btn_run 1 cycle (glitch shorter than DB_CYCLES) -> no event, FSM unchanged.
- In RUN, press load with sw_data=0xA5 -> one cycle cnt_load=1 with load_data=0xA5, no cnt_step that cycle, FSM back in RUN.
- Press clr and load simultaneously in PAUSE with cnt_dir=1 -> only cnt_clr pulses, cnt_dir=0, FSM=IDLE, load dropped.
- Press dir twice in RUN -> cnt_dir goes 1 then 0; step cadence unchanged; run, pause, run -> prescaler resumes from its held value.
- Define COUNTER_CTRL_AUTO_RELOAD_EN, load 0x10, up, drive cnt_q=0xFF at tick -> cnt_load with load_data=0x10, no cnt_step. Then assert clr_n=0 mid-run -> all outputs 0 immediately.
